// File: rtl/sedec_pkg.sv
// Shared types and default sizes for the serial detector scheduler.
package sedec_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sedec_rr_arb.sv
// Two-way round-robin arbiter; the last-served flag favours the other requester on a tie.
module sedec_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  logic last;

  // last=1 means requester 1 was served most recently, so req0 wins the first tie
  assign gnt0 = en & req0 & (~req1 | last);
  assign gnt1 = en & req1 & (~req0 | ~last);

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last <= gnt1;
    end
  end
endmodule

// File: rtl/sedec_sched.sv
// Schedules two requesters' words through an external serial sequence detector and counts hits.
// Optional build macro SEDEC_SCHED_ABORT_EN adds an abort input that cancels a scan in progress.
module sedec_sched
  import sedec_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] word0,
  input  logic [WORD_W-1:0] word1,
`ifdef SEDEC_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              det_rst,
  output logic              det_in,
  input  logic              det_hit,
  output logic              busy,
  output logic              done,
  output logic              owner,
  output logic [CNT_W-1:0]  hits,
  output logic [1:0]        dbg_state
);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] word_sel;
  logic [BIT_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              count_en;
  logic              abort_now;

  sedec_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == IDLE) & ~rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

`ifdef SEDEC_SCHED_ABORT_EN
  assign abort_now = abort & ((state == SHIFT) | (state == DRAIN));
`else
  assign abort_now = 1'b0;
`endif

  assign word_sel  = gnt1 ? word1 : word0;
  assign dbg_state = state;

  // The detector output lags its input by one cycle, so the first SHIFT cycle
  // still shows the reset state and the DRAIN cycle carries the last bit's result.
  assign count_en = det_hit & (((state == SHIFT) & (bitcnt != '0)) | (state == DRAIN));
  assign cnt_next = (count_en && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bitcnt  <= '0;
      cnt     <= '0;
      hits    <= '0;
      owner   <= 1'b0;
      det_in  <= 1'b0;
      det_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort_now) begin
      state   <= IDLE;
      det_in  <= 1'b0;
      det_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (gnt0 | gnt1) begin
            state   <= SHIFT;
            owner   <= gnt1;
            sr      <= word_sel << 1;
            det_in  <= word_sel[WORD_W-1];
            bitcnt  <= '0;
            cnt     <= '0;
            det_rst <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          cnt    <= cnt_next;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            state  <= DRAIN;
            det_in <= 1'b0;
          end else begin
            det_in <= sr[WORD_W-1];
            sr     <= sr << 1;
          end
        end
        DRAIN: begin
          cnt     <= cnt_next;
          hits    <= cnt_next;
          state   <= DONE;
          det_rst <= 1'b1;
          done    <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sedec_sched.sv
// Directed bench for sedec_sched with an overlapping "1011" Moore detector model and hit scoreboard.
module tb_sedec_sched;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] word0 = '0, word1 = '0;
  logic gnt0, gnt1, det_rst, det_in, det_hit, busy, done, owner;
  logic [4:0] hits;
  logic [1:0] dbg_state;
`ifdef SEDEC_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif

  logic s_req0 = 1'b0;
  logic [W-1:0] s_word0 = '0;
  logic s_gnt0, s_gnt1, s_det_rst, s_det_in, s_det_hit, s_busy, s_done, s_owner;
  logic [1:0] s_hits;
  logic [1:0] s_dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  sedec_sched #(.WORD_W(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .word0(word0), .word1(word1),
`ifdef SEDEC_SCHED_ABORT_EN
    .abort(abort),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .det_rst(det_rst), .det_in(det_in), .det_hit(det_hit),
    .busy(busy), .done(done), .owner(owner), .hits(hits), .dbg_state(dbg_state)
  );

  sedec_sched #(.WORD_W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req0(s_req0), .req1(1'b0), .word0(s_word0), .word1('0),
`ifdef SEDEC_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .gnt0(s_gnt0), .gnt1(s_gnt1), .det_rst(s_det_rst), .det_in(s_det_in), .det_hit(s_det_hit),
    .busy(s_busy), .done(s_done), .owner(s_owner), .hits(s_hits), .dbg_state(s_dbg_state)
  );

  // Overlapping "1011" Moore detector: 0=none 1="1" 2="10" 3="101" 4="1011"
  function automatic logic [2:0] det_next(input logic [2:0] st, input logic b);
    case (st)
      3'd0: return b ? 3'd1 : 3'd0;
      3'd1: return b ? 3'd1 : 3'd2;
      3'd2: return b ? 3'd3 : 3'd0;
      3'd3: return b ? 3'd4 : 3'd2;
      3'd4: return b ? 3'd1 : 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] det_st = 3'd0, s_det_st = 3'd0;
  always @(posedge clk) det_st <= det_rst ? 3'd0 : det_next(det_st, det_in);
  always @(posedge clk) s_det_st <= s_det_rst ? 3'd0 : det_next(s_det_st, s_det_in);
  assign det_hit = (det_st == 3'd4);
  assign s_det_hit = (s_det_st == 3'd4);

  function automatic int exp_hits(input logic [W-1:0] w, input int cw);
    int n = 0;
    for (int i = 0; i <= W - 4; i++) if (w[W-1-i -: 4] == 4'b1011) n++;
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: push {owner, hits} on a grant, pop and compare on done.
  always @(negedge clk) begin
    if (gnt0 | gnt1) begin
      check("gnt_onehot_idle", {gnt0 & gnt1, busy}, 2'b00);
      exp_q.push_back({gnt1, 5'(exp_hits(gnt1 ? word1 : word0, 5))});
    end
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("owner_hits", {owner, hits}, exp_q.pop_front());
    end
  end

  task automatic wait_gnt(output logic who);
    who = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        who = gnt1;
        return;
      end
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_word(input logic who, input logic [W-1:0] w);
    logic got;
    @(posedge clk); #1;
    if (who) begin req1 = 1'b1; word1 = w; end
    else begin req0 = 1'b1; word0 = w; end
    wait_gnt(got);
    check("gnt_who", got, who);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("det_in_bit", {det_in, det_rst, busy, done}, {w[W-1-k], 3'b010});
    end
    @(negedge clk);
    check("drain", {det_in, det_rst, busy, done}, 4'b0010);
    @(negedge clk);
    check("done_latency", {done, busy, det_rst}, 3'b111);
  endtask

  initial begin
    logic got;
    int ndone;
    repeat (3) @(posedge clk);
    #1 req0 = 1'b1;
    @(negedge clk);
    check("rst_outputs", {gnt0, gnt1, det_in, det_rst, busy, done, owner}, 7'b0001000);
    check("rst_hits", hits, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b0;

    // Tie from reset: 0, then 1, then 0 again
    @(posedge clk); #1;
    word0 = 16'hB6B3; word1 = 16'hBBBB; req0 = 1'b1; req1 = 1'b1;
    wait_gnt(got); check("tie1", got, 0);
    wait_done();
    wait_gnt(got); check("tie2", got, 1);
    wait_done();
    wait_gnt(got); check("tie3", got, 0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_done();

    run_word(1'b0, 16'hB6B3);
    check("hits_b6b3", hits, 3);
    run_word(1'b0, 16'hFFFF);
    check("hits_ffff", hits, 0);
    run_word(1'b1, 16'hBBBB);
    check("hits_bbbb", {owner, hits}, {1'b1, 5'd4});
    repeat (5) @(negedge clk);
    check("hits_hold", {busy, hits}, {1'b0, 5'd4});

    // Reset during SHIFT cycle 7
    @(posedge clk); #1;
    req0 = 1'b1; word0 = 16'hBBBB;
    wait_gnt(got);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pre_rst_shift", {dbg_state, busy}, {2'd1, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst", {dbg_state, busy, det_rst, done}, {2'd0, 3'b010});
    check("post_rst_hits", hits, 0);
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_rst", ndone, 0);

`ifdef SEDEC_SCHED_ABORT_EN
    run_word(1'b0, 16'hBBBB);
    @(posedge clk); #1;
    req0 = 1'b1; word0 = 16'hB6B3;
    wait_gnt(got);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_idle", {dbg_state, busy, det_rst, done}, {2'd0, 3'b010});
    check("abort_hits", hits, 4);
    @(posedge clk); #1;
    word1 = 16'hFFFF; req0 = 1'b1; req1 = 1'b1;
    wait_gnt(got); check("abort_last_served", got, 1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_done();
`endif

    // Saturating 2-bit counter
    @(posedge clk); #1;
    s_req0 = 1'b1; s_word0 = 16'hBBBB;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = s_gnt0;
    end
    check("sat_gnt", got, 1);
    @(posedge clk); #1;
    s_req0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = s_done;
    end
    check("sat_done", got, 1);
    check("sat_hits", s_hits, exp_hits(16'hBBBB, 2));

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sedec_sched.md
SEDEC_SCHED -- requirements
Module: sedec_sched

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning serial word length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 5, meaning hit-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: requester wants a word scanned, held until granted.
REQ-006 The block SHALL have ports word0/word1, input, WORD_W bits each: requester word, MSB scanned first.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle grant, the word is latched on this edge.
REQ-008 The block SHALL have port det_rst, output, 1 bit: drives the external sequence detector's synchronous reset.
REQ-009 The block SHALL have port det_in, output, 1 bit: serial bit to the detector.
REQ-010 The block SHALL have port det_hit, input, 1 bit: detector output (Moore, valid the cycle after the bit is clocked).
REQ-011 The block SHALL have ports busy, done, owner, output, 1 bit each: scan in progress, one-cycle completion pulse, and served requester (0/1).
REQ-012 The block SHALL have port hits, output, CNT_W bits: detections counted in the last completed word.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DRAIN and DONE.
REQ-014 IDLE: if any req is high, the block SHALL assert the matching gnt (combinational), latch the word into the shift register, set owner, clear the internal count, and go to SHIFT.
REQ-015 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; after reset, req0 wins the first tie.
REQ-016 gnt0 and gnt1 SHALL never be high together and SHALL only assert in IDLE.
REQ-017 SHIFT SHALL last exactly WORD_W cycles; in cycle k (0..WORD_W-1), det_in = word[WORD_W-1-k].
REQ-018 det_hit SHALL be counted in SHIFT cycles 1..WORD_W-1 and in the single DRAIN cycle; det_hit in SHIFT cycle 0 SHALL be ignored.
REQ-019 DRAIN SHALL last 1 cycle with det_in=0, then go to DONE.
REQ-020 DONE SHALL last 1 cycle: done=1, hits updated from the internal count, then go to IDLE.
REQ-021 hits SHALL hold its value until the next DONE.
REQ-022 The counter SHALL saturate at 2^CNT_W-1.
REQ-023 det_rst SHALL be 1 in IDLE and DONE and 0 in SHIFT and DRAIN, so each word starts from the detector reset state.
REQ-024 busy SHALL be 1 in SHIFT, DRAIN and DONE.
REQ-025 Requests arriving outside IDLE SHALL wait; there is no queueing beyond the req level.
REQ-026 Fixed latency: from gnt edge to done SHALL be WORD_W+2 cycles; back-to-back words SHALL be separated by at least 1 IDLE cycle.

Reset
REQ-027 rst=1 at any clock edge, including mid-SHIFT, SHALL force IDLE and discard the scan.
REQ-028 Reset values SHALL be: gnt0=gnt1=0, det_in=0, det_rst=1, busy=0, done=0, hits=0, owner=0; last-served=1.

Configuration
REQ-029 With SEDEC_SCHED_ABORT_EN defined, the block SHALL have input abort (1 bit); abort=1 in SHIFT or DRAIN SHALL cause IDLE next cycle, with no done, hits unchanged, and last-served updated to the aborted owner.
REQ-030 Without SEDEC_SCHED_ABORT_EN, the abort port and logic SHALL be absent.

Structure
REQ-031 Package sedec_pkg SHALL hold state_t (IDLE/SHIFT/DRAIN/DONE) and the default WORD_W/CNT_W constants.
REQ-032 One sub-module, sedec_rr_arb, SHALL implement the 2-way round-robin grant and last-served flag.
REQ-033 The shift register, bit counter and hit counter SHALL live in sedec_sched.

Verification
REQ-034 The bench detector model SHALL be the overlapping "1011" Moore detector.
REQ-035 Scenario: req0=1, word0=16'hB6B3 -> gnt0 for 1 cycle; det_in streams 1011011010110011; done 18 cycles after gnt; hits=3; owner=0.
REQ-036 Scenario: req0=req1=1 from reset -> gnt0 first; after done, gnt1 granted; a third tie goes to req0.
REQ-037 Scenario: word=16'hFFFF -> hits=0; word=16'hBBBB -> hits=4.
REQ-038 Scenario: rst pulse in SHIFT cycle 7 -> next cycle IDLE, busy=0, det_rst=1, no done, hits=0.
REQ-039 Scenario: CNT_W=2, word=16'hBBBB -> hits saturates at 3.
REQ-040 Scenario (ABORT_EN): abort in SHIFT cycle 3 -> IDLE next cycle, no done, prior hits retained.
